// File: rtl/opld_pkg.sv
// Shared definitions for the operand loader: FSM state encoding, default widths
// and the LFSR seed/taps used by the optional self-generate path (OPLD_LFSR_EN).
// No logic here; imported by operand_loader and opld_lfsr.
package opld_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam int OP_W_DEF   = 36;
  localparam int BEAT_W_DEF = 9;
  localparam int CNT_W_DEF  = 16;

  localparam int                LFSR_W      = 36;
  localparam logic [LFSR_W-1:0] LFSR_SEED   = 36'h1;
  localparam int                LFSR_TAP_HI = 35;
  localparam int                LFSR_TAP_LO = 24;

  // One Fibonacci step: shift left, feedback of the two taps into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/opld_lfsr.sv
// 36-bit Fibonacci LFSR used to self-generate operand pairs.
// Value is registered; it steps once per cycle that advance is high.
// Synchronous active-high reset reloads the seed.
module opld_lfsr
  import opld_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  // Hold the current value, step only when a generated pair is launched.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Assembles BEAT_W-bit beats (A beats LSB first, then B beats) into an OP_W-bit
// operand pair presented to the ALU; op_valid rises the cycle after the last B beat.
// in_ready drops while a pair is presented; optional LFSR self-generate under OPLD_LFSR_EN.
module operand_loader
  import opld_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_abort,
  input  logic              gen_mode,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  pair_cnt
);

  localparam int BEATS = OP_W / BEAT_W;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  state_t          state;
  logic [BC_W-1:0] beat_cnt;
  logic [OP_W-1:0] stg_a;
  logic [OP_W-1:0] stg_b;
  logic [OP_W-1:0] stg_b_nxt;
  logic            gen_go;
  logic            accept;

`ifdef OPLD_LFSR_EN
  logic [LFSR_W-1:0] lfsr_val;

  // A generate request is only honoured at a pair boundary; abort wins.
  assign gen_go = (state == LOAD_A) && (beat_cnt == '0) && gen_mode && !in_abort;

  opld_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (gen_go),
    .value   (lfsr_val)
  );
`else
  logic unused_gen_mode;
  assign unused_gen_mode = gen_mode;
  assign gen_go          = 1'b0;
`endif

  assign in_ready = (state != PRESENT) && !in_abort && !gen_go;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != LOAD_A) || (beat_cnt != '0);

  // B staging with the current beat merged in, so the final beat reaches op_b directly.
  always_comb begin
    stg_b_nxt = stg_b;
    stg_b_nxt[beat_cnt*BEAT_W +: BEAT_W] = in_data;
  end

  // Loader FSM: beat collection, staging, output registers and pair counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_A;
      beat_cnt <= '0;
      stg_a    <= '0;
      stg_b    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      pair_cnt <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_abort) begin
            beat_cnt <= '0;
            stg_a    <= '0;
            stg_b    <= '0;
`ifdef OPLD_LFSR_EN
          end else if (gen_go) begin
            op_a     <= OP_W'(lfsr_val);
            op_b     <= OP_W'(~lfsr_val);
            op_valid <= 1'b1;
            state    <= PRESENT;
`endif
          end else if (accept) begin
            stg_a[beat_cnt*BEAT_W +: BEAT_W] <= in_data;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= LOAD_B;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        LOAD_B: begin
          if (in_abort) begin
            beat_cnt <= '0;
            stg_a    <= '0;
            stg_b    <= '0;
            state    <= LOAD_A;
          end else if (accept) begin
            stg_b <= stg_b_nxt;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              op_a     <= stg_a;
              op_b     <= stg_b_nxt;
              op_valid <= 1'b1;
              state    <= PRESENT;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        PRESENT: begin
          // op_valid is always set here; abort has no effect on a presented pair.
          if (op_valid && op_ready) begin
            op_valid <= 1'b0;
            pair_cnt <= pair_cnt + 1'b1;
            state    <= LOAD_A;
          end
        end

        default: begin
          state    <= LOAD_A;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed scenarios plus randomized
// pairs, gaps, aborts and ALU stalls against a pair-level reference model.
// pair_cnt is narrowed to 8 bits so counter wrap is reached in a short run.
module tb_operand_loader;

  localparam int OP_W   = 36;
  localparam int BEAT_W = 9;
  localparam int CNT_W  = 8;
  localparam int BEATS  = OP_W / BEAT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BEAT_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_abort = 1'b0;
  logic              gen_mode = 1'b0;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              op_valid;
  logic              op_ready = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  pair_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: last delivered pair and total pairs handed over.
  logic [OP_W-1:0] exp_a = '0;
  logic [OP_W-1:0] exp_b = '0;
  int              exp_cnt = 0;

  operand_loader #(.OP_W(OP_W), .BEAT_W(BEAT_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_abort (in_abort),
    .gen_mode (gen_mode),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .busy     (busy),
    .pair_cnt (pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_pc();
    return CNT_W'(exp_cnt % (1 << CNT_W));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_abort = 1'b0; op_ready = 1'b0; gen_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_a = '0; exp_b = '0; exp_cnt = 0;
    #1;
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_pair_cnt", pair_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [BEAT_W-1:0] d);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_pair(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input int gap_max);
    logic [OP_W-1:0] w;
    for (int i = 0; i < 2*BEATS; i++) begin
      w = (i < BEATS) ? a : b;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      if (i == 2*BEATS-1) chk("valid_before_last", op_valid, 0);
      if (i == BEATS) begin
        chk("op_a_stable_load", op_a, exp_a);
        chk("op_b_stable_load", op_b, exp_b);
      end
      send_beat(w[(i % BEATS)*BEAT_W +: BEAT_W]);
    end
    exp_a = a; exp_b = b;
    chk("valid_latency", op_valid, 1);
    chk("pair_op_a", op_a, exp_a);
    chk("pair_op_b", op_b, exp_b);
  endtask

  // Stall the ALU side for 'delay' cycles, then take the pair.
  task automatic consume(input int delay);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      op_ready = 1'b0;
      in_abort = 1'($urandom_range(0, 1));
      #1;
      chk("hold_valid", op_valid, 1);
      chk("hold_op_a", op_a, exp_a);
      chk("hold_op_b", op_b, exp_b);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_abort = 1'b0; op_ready = 1'b1;
    #1;
    chk("ready_not_same_cycle", in_ready, 0);
    @(posedge clk); #1;
    op_ready = 1'b0;
    exp_cnt++;
    chk("hs_valid_drop", op_valid, 0);
    chk("hs_pair_cnt", pair_cnt, exp_pc());
    chk("hs_in_ready", in_ready, 1);
    chk("hs_busy", busy, 0);
    chk("hs_op_a_kept", op_a, exp_a);
    chk("hs_op_b_kept", op_b, exp_b);
  endtask

  // Abort with a beat presented in the same cycle; the beat must be lost.
  task automatic abort_now(input logic [BEAT_W-1:0] d);
    @(negedge clk);
    in_abort = 1'b1; in_valid = 1'b1; in_data = d;
    #1;
    chk("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", op_valid, 0);
    chk("abort_op_a", op_a, exp_a);
    chk("abort_op_b", op_b, exp_b);
  endtask

  function automatic logic [OP_W-1:0] rnd_op();
    return {$urandom_range(0, 15), $urandom()};
  endfunction

  initial begin
    logic [OP_W-1:0] ra, rb;
    int k;

    // Reset
    do_reset();

    // Directed pair, ALU ready immediately
    load_pair(36'h123456789, 36'hFFFFFFFFF, 0);
    consume(0);

    // Same pair with a 5-cycle ALU stall
    load_pair(36'h123456789, 36'hFFFFFFFFF, 0);
    consume(5);

    // Partial load of 5 beats, abort with concurrent beat, then full reload
    for (int i = 0; i < 5; i++) send_beat(9'h0AA + 9'(i));
    abort_now(9'h1C3);
    load_pair(36'h0DEADBEEF, 36'h987654321, 0);
    consume(1);

    // Reset after 6 beats, then a fresh load
    for (int i = 0; i < 6; i++) send_beat(9'h055);
    do_reset();
    load_pair(36'hA5A5A5A5A, 36'h5A5A5A5A5, 0);
    consume(0);

`ifdef OPLD_LFSR_EN
    // Self-generated pairs from the seeded LFSR
    @(negedge clk);
    gen_mode = 1'b1; #1;
    chk("gen_in_ready", in_ready, 0);
    @(posedge clk); #1;
    gen_mode = 1'b0;
    exp_a = 36'h1; exp_b = 36'hFFFFFFFFE;
    chk("gen1_valid", op_valid, 1);
    chk("gen1_op_a", op_a, exp_a);
    chk("gen1_op_b", op_b, exp_b);
    consume(0);
    @(negedge clk);
    gen_mode = 1'b1;
    @(posedge clk); #1;
    gen_mode = 1'b0;
    exp_a = 36'h2; exp_b = 36'hFFFFFFFFD;
    chk("gen2_valid", op_valid, 1);
    chk("gen2_op_a", op_a, exp_a);
    chk("gen2_op_b", op_b, exp_b);
    consume(0);
`endif

    // Randomized pairs with gaps, aborts and stalls; enough to wrap pair_cnt
    for (int n = 0; n < 300; n++) begin
`ifndef OPLD_LFSR_EN
      gen_mode = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, 2*BEATS-1);
        for (int i = 0; i < k; i++) send_beat(9'($urandom()));
        abort_now(9'($urandom()));
      end
      ra = rnd_op();
      rb = rnd_op();
      load_pair(ra, rb, (n % 3 == 0) ? 2 : 0);
      consume($urandom_range(0, 3));
      if (exp_cnt % (1 << CNT_W) == 0) chk("cnt_wrap", pair_cnt, 0);
    end
    gen_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_err++;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $fatal(1);
  end

endmodule
